// File: rtl/entropy_src_cond_seq.sv
// Conditioner-side SHA3-384 block sequencer: packs raw words into rate blocks,
// pads the final block and hands blocks to the Keccak core over req/ack.
module entropy_src_cond_seq #(
    parameter int MsgWidth  = 64,
    parameter int RateWords = 13,
    parameter int CntWidth  = 4
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          start_i,
    input  logic                          process_i,
    input  logic [3:0]                    done_i,
    input  logic                          msg_valid_i,
    input  logic [MsgWidth-1:0]           msg_data_i,
    output logic                          msg_ready_o,
    output logic                          perm_req_o,
    output logic                          perm_final_o,
    output logic [RateWords*MsgWidth-1:0] perm_block_o,
    input  logic                          perm_ack_i,
    output logic                          state_vld_o,
    output logic                          idle_o,
    output logic [CntWidth-1:0]           word_cnt_o,
    output logic                          err_o
);

    localparam logic [3:0] MuBi4True  = 4'h6;
    localparam logic [3:0] MuBi4False = 4'h9;
    localparam logic [CntWidth-1:0] RateCnt = CntWidth'(RateWords);

    typedef enum logic [2:0] {
        Idle      = 3'd0,
        Absorb    = 3'd1,
        PermBusy  = 3'd2,
        PadBlock  = 3'd3,
        PermFinal = 3'd4,
        Valid     = 3'd5,
        Error     = 3'd6
    } state_e;

    state_e state_q, state_d;
    logic [RateWords-1:0][MsgWidth-1:0] buf_q, buf_d;
    logic [CntWidth-1:0] cnt_q, cnt_d;
    logic pend_proc_q, pend_proc_d;
    logic pend_done_q, pend_done_d;
    logic done_true, done_bad;

    assign done_true = (done_i == MuBi4True);
    assign done_bad  = !done_true && (done_i != MuBi4False);

    always_comb begin
        state_d      = state_q;
        buf_d        = buf_q;
        cnt_d        = cnt_q;
        pend_proc_d  = pend_proc_q;
        pend_done_d  = pend_done_q;
        msg_ready_o  = 1'b0;
        perm_req_o   = 1'b0;
        perm_final_o = 1'b0;
        state_vld_o  = 1'b0;
        idle_o       = 1'b0;
        err_o        = 1'b0;

        case (state_q)
            Idle: begin
                idle_o = 1'b1;
                if (start_i) begin
                    state_d     = Absorb;
                    cnt_d       = '0;
                    buf_d       = '0;
                    pend_proc_d = 1'b0;
                    pend_done_d = 1'b0;
                end
            end
            Absorb: begin
                msg_ready_o = 1'b1;
                if (done_true) begin
                    state_d = Idle;
                    cnt_d   = '0;
                    buf_d   = '0;
                end else if (start_i) begin
                    cnt_d = '0;
                    buf_d = '0;
                end else begin
                    if (msg_valid_i) begin
                        buf_d[cnt_q] = msg_data_i;
                        cnt_d        = cnt_q + CntWidth'(1);
                    end
                    // a word landing with process is counted before padding
                    if (cnt_d == RateCnt) begin
                        state_d     = PermBusy;
                        pend_proc_d = process_i;
                    end else if (process_i) begin
                        state_d = PadBlock;
                    end
                end
            end
            PermBusy: begin
                perm_req_o = 1'b1;
                if (process_i) pend_proc_d = 1'b1;
                if (done_true) pend_done_d = 1'b1;
                if (perm_ack_i) begin
                    cnt_d = '0;
                    buf_d = '0;
                    if (pend_done_q || done_true) begin
                        state_d     = Idle;
                        pend_proc_d = 1'b0;
                        pend_done_d = 1'b0;
                    end else if (pend_proc_q || process_i) begin
                        state_d     = PadBlock;
                        pend_proc_d = 1'b0;
                    end else begin
                        state_d = Absorb;
                    end
                end
            end
            PadBlock: begin
                if (done_true) begin
                    state_d = Idle;
                    cnt_d   = '0;
                    buf_d   = '0;
                end else begin
                    // both pad bits may land in the same word when cnt is the last slot
                    buf_d[cnt_q][7:0] = buf_q[cnt_q][7:0] ^ 8'h06;
                    buf_d[RateWords-1][MsgWidth-1] = ~buf_d[RateWords-1][MsgWidth-1];
                    state_d = PermFinal;
                end
            end
            PermFinal: begin
                perm_req_o   = 1'b1;
                perm_final_o = 1'b1;
                if (done_true) pend_done_d = 1'b1;
                if (perm_ack_i) begin
                    if (pend_done_q || done_true) begin
                        state_d     = Idle;
                        cnt_d       = '0;
                        buf_d       = '0;
                        pend_proc_d = 1'b0;
                        pend_done_d = 1'b0;
                    end else begin
                        state_d = Valid;
                    end
                end
            end
            Valid: begin
                state_vld_o = 1'b1;
                if (done_true) begin
                    state_d     = Idle;
                    cnt_d       = '0;
                    buf_d       = '0;
                    pend_proc_d = 1'b0;
                    pend_done_d = 1'b0;
                end
            end
            Error: begin
                err_o = 1'b1;
            end
            default: begin
                state_d = Error;
            end
        endcase

        if (done_bad ||
            (start_i && (state_q == PermBusy || state_q == PermFinal ||
                         state_q == PadBlock))) begin
            state_d = Error;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q     <= Idle;
            buf_q       <= '0;
            cnt_q       <= '0;
            pend_proc_q <= 1'b0;
            pend_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            buf_q       <= buf_d;
            cnt_q       <= cnt_d;
            pend_proc_q <= pend_proc_d;
            pend_done_q <= pend_done_d;
        end
    end

    assign perm_block_o = buf_q;
    assign word_cnt_o   = cnt_q;

endmodule
